// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 4-bit IEEE 1149.1 state encoding, fixed opcodes and the state transition function.
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TAP_EXIT2_DR = 4'h0,
      TAP_EXIT1_DR = 4'h1,
      TAP_SHIFT_DR = 4'h2,
      TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4,
      TAP_UPD_DR   = 4'h5,
      TAP_CAP_DR   = 4'h6,
      TAP_SEL_DR   = 4'h7,
      TAP_EXIT2_IR = 4'h8,
      TAP_EXIT1_IR = 4'h9,
      TAP_SHIFT_IR = 4'hA,
      TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC,
      TAP_UPD_IR   = 4'hD,
      TAP_CAP_IR   = 4'hE,
      TAP_TLR      = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USER
   } dr_sel_e;

   localparam logic [4:0] OPC_IDCODE = 5'h01;
   localparam logic [4:0] OPC_BYPASS = 5'h1F;
   localparam int         IDCODE_W   = 32;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_next = s;
      case (s)
         TAP_TLR:      tap_next = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   tap_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: tap_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: tap_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: tap_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   tap_next = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: tap_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: tap_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: tap_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      tap_next = TAP_TLR;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tck_sync.sv
// Brings TCK/TMS/TDI into the CLK domain through 2-flop synchronizers and detects TCK edges.
module jtag_tck_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic tck_i,
   input  logic tms_i,
   input  logic tdi_i,
   output logic tck_rise_o,
   output logic tck_fall_o,
   output logic tms_o,
   output logic tdi_o
);

   logic [1:0] tck_q, tms_q, tdi_q;
   logic       tck_prev_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tck_q      <= '0;
         tms_q      <= '0;
         tdi_q      <= '0;
         tck_prev_q <= 1'b0;
      end else begin
         tck_q      <= {tck_q[0], tck_i};
         tms_q      <= {tms_q[0], tms_i};
         tdi_q      <= {tdi_q[0], tdi_i};
         tck_prev_q <= tck_q[1];
      end
   end

   assign tck_rise_o = tck_q[1] & ~tck_prev_q;
   assign tck_fall_o = ~tck_q[1] & tck_prev_q;
   assign tms_o      = tms_q[1];
   assign tdi_o      = tdi_q[1];

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG TAP slave run entirely on CLK; TCK is oversampled and its edges drive the TAP FSM.
// Optional USER data register is enabled by defining JTAG_TAP_USER_DR_EN.
module jtag_tap_slave
   import jtag_tap_pkg::*;
#(
   parameter int                    C_IR_WIDTH      = 5,
   parameter int                    C_USER_DR_WIDTH = 32,
   parameter logic [31:0]           C_IDCODE        = 32'h10000001,
   parameter logic [C_IR_WIDTH-1:0] C_IR_USER       = C_IR_WIDTH'(5'h10)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       tck_i,
   input  logic                       tms_i,
   input  logic                       tdi_i,
   output logic                       tdo_o,
   output logic                       tdo_oe_o,
   input  logic [C_USER_DR_WIDTH-1:0] user_capture_i,
   output logic [C_USER_DR_WIDTH-1:0] user_update_o,
   output logic                       user_update_vld_o,
   output logic [3:0]                 tap_state_o
);

   localparam int DRW = (C_USER_DR_WIDTH > IDCODE_W) ? C_USER_DR_WIDTH : IDCODE_W;
   localparam int DLW = $clog2(DRW);
   localparam logic [C_IR_WIDTH-1:0] IR_IDCODE  = C_IR_WIDTH'(OPC_IDCODE);
   localparam logic [C_IR_WIDTH-1:0] IR_BYPASS  = {C_IR_WIDTH{OPC_BYPASS[0]}};
   localparam logic [C_IR_WIDTH-1:0] IR_CAPTURE = C_IR_WIDTH'(2'b01);

   logic tck_rise, tck_fall, tms_s, tdi_s;

   tap_state_e                 state_q, state_d;
   logic [C_IR_WIDTH-1:0]      ir_q, ir_d, ir_sr_q, ir_sr_d;
   logic [DRW-1:0]             dr_sr_q, dr_sr_d, dr_cap, dr_shift;
   logic [DLW-1:0]             dr_msb;
   dr_sel_e                    dr_sel;
   logic                       tdo_q, tdo_d, oe_q, oe_d;
   logic [C_USER_DR_WIDTH-1:0] upd_q, upd_d;
   logic                       vld_q, vld_d;

   jtag_tck_sync u_sync (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .tck_i      (tck_i),
      .tms_i      (tms_i),
      .tdi_i      (tdi_i),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall),
      .tms_o      (tms_s),
      .tdi_o      (tdi_s)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= TAP_TLR;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tck_rise) state_d = tap_next(state_q, tms_s);
   end

   // Without the USER register its opcode falls through to BYPASS, so USER outputs stay at reset value.
   always_comb begin
      dr_sel = DR_BYPASS;
      if (ir_q == IR_BYPASS)      dr_sel = DR_BYPASS;
      else if (ir_q == IR_IDCODE) dr_sel = DR_IDCODE;
`ifdef JTAG_TAP_USER_DR_EN
      else if (ir_q == C_IR_USER) dr_sel = DR_USER;
`endif
   end

`ifndef JTAG_TAP_USER_DR_EN
   logic unused_ir_user;
   assign unused_ir_user = ^C_IR_USER;
`endif

   always_comb begin
      dr_cap = '0;
      dr_msb = '0;
      case (dr_sel)
         DR_IDCODE: begin
            dr_cap[IDCODE_W-1:0] = C_IDCODE;
            dr_msb               = DLW'(IDCODE_W - 1);
         end
         DR_USER: begin
            dr_cap[C_USER_DR_WIDTH-1:0] = user_capture_i;
            dr_msb                      = DLW'(C_USER_DR_WIDTH - 1);
         end
         default: ;
      endcase
      // TDI enters at the MSB of the active register length, not of the shared shifter.
      dr_shift         = dr_sr_q >> 1;
      dr_shift[dr_msb] = tdi_s;
   end

   always_comb begin
      ir_d    = ir_q;
      ir_sr_d = ir_sr_q;
      dr_sr_d = dr_sr_q;
      tdo_d   = tdo_q;
      oe_d    = oe_q;
      upd_d   = upd_q;
      vld_d   = 1'b0;
      if (tck_rise) begin
         case (state_q)
            TAP_CAP_IR:   ir_sr_d = IR_CAPTURE;
            TAP_SHIFT_IR: ir_sr_d = {tdi_s, ir_sr_q[C_IR_WIDTH-1:1]};
            TAP_UPD_IR:   ir_d    = ir_sr_q;
            TAP_CAP_DR:   dr_sr_d = dr_cap;
            TAP_SHIFT_DR: dr_sr_d = dr_shift;
            TAP_UPD_DR: begin
               if (dr_sel == DR_USER) begin
                  upd_d = dr_sr_q[C_USER_DR_WIDTH-1:0];
                  vld_d = 1'b1;
               end
            end
            default: ;
         endcase
         if (state_d == TAP_TLR) ir_d = IR_IDCODE;
      end
      if (tck_fall) begin
         tdo_d = 1'b0;
         oe_d  = 1'b0;
         if (state_q == TAP_SHIFT_IR) begin
            tdo_d = ir_sr_q[0];
            oe_d  = 1'b1;
         end else if (state_q == TAP_SHIFT_DR) begin
            tdo_d = dr_sr_q[0];
            oe_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ir_q    <= IR_IDCODE;
         ir_sr_q <= '0;
         dr_sr_q <= '0;
         tdo_q   <= 1'b0;
         oe_q    <= 1'b0;
         upd_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         ir_sr_q <= ir_sr_d;
         dr_sr_q <= dr_sr_d;
         tdo_q   <= tdo_d;
         oe_q    <= oe_d;
         upd_q   <= upd_d;
         vld_q   <= vld_d;
      end
   end

   assign tdo_o             = tdo_q;
   assign tdo_oe_o          = oe_q;
   assign user_update_o     = upd_q;
   assign user_update_vld_o = vld_q;
   assign tap_state_o       = state_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Self-checking bench for jtag_tap_slave: TCK driven at 1/12 of CLK, TDO checked against a queue of expected bits.
module tb_jtag_tap_slave;
   import jtag_tap_pkg::*;

   localparam int TCK_HALF = 60;

   logic        clk = 1'b0;
   logic        rst, tck, tms, tdi;
   logic        tdo, tdo_oe, user_update_vld;
   logic [31:0] user_capture, user_update;
   logic [3:0]  tap_state;

   int vectors = 0;
   int miscompares = 0;
   int vld_cnt = 0;

   logic       exp_q[$];
   logic [1:0] obs_q[$];

   jtag_tap_slave dut (
      .clk_i             (clk),
      .reset_i           (rst),
      .tck_i             (tck),
      .tms_i             (tms),
      .tdi_i             (tdi),
      .tdo_o             (tdo),
      .tdo_oe_o          (tdo_oe),
      .user_capture_i    (user_capture),
      .user_update_o     (user_update),
      .user_update_vld_o (user_update_vld),
      .tap_state_o       (tap_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (user_update_vld === 1'b1) vld_cnt <= vld_cnt + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog");
   end

   // One TCK period: TDO/OE are sampled at the end of the low phase, just before the rise.
   task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_s, output logic oe_s);
      tms = tms_v;
      tdi = tdi_v;
      #(TCK_HALF);
      tdo_s = tdo;
      oe_s  = tdo_oe;
      tck = 1'b1;
      #(TCK_HALF);
      tck = 1'b0;
   endtask

   task automatic walk(input logic [7:0] seq, input int n);
      logic t, o;
      for (int i = 0; i < n; i++) tck_cycle(seq[i], 1'b0, t, o);
   endtask

   task automatic shift_bits(input int n, input logic [31:0] din, input logic do_exit);
      logic t, o;
      for (int i = 0; i < n; i++) begin
         tck_cycle(do_exit && (i == n - 1), din[i], t, o);
         obs_q.push_back({o, t});
      end
   endtask

   task automatic load_ir(input logic [4:0] op);
      walk(8'b0011, 4);
      shift_bits(5, 32'(op), 1'b1);
      obs_q.delete();
      walk(8'b01, 2);
   endtask

   task automatic test_reset();
      tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_capture = '0;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (tap_state !== TAP_TLR) begin
         miscompares++; $display("FAIL reset_state: got %h want %h", tap_state, TAP_TLR);
      end
      vectors++;
      if ({tdo, tdo_oe, user_update_vld} !== 3'b000 || user_update !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: tdo=%b oe=%b vld=%b upd=%h want all zero", tdo, tdo_oe, user_update_vld, user_update);
      end
      walk(8'b0010, 4);
      #(TCK_HALF);
      vectors++;
      if (tap_state !== TAP_SHIFT_DR || tdo_oe !== 1'b1 || tdo !== 1'b1) begin
         miscompares++;
         $display("FAIL enter_shift_dr: state=%h oe=%b tdo=%b want %h 1 1", tap_state, tdo_oe, tdo, TAP_SHIFT_DR);
      end
      walk(8'b11111, 5);
      #(TCK_HALF);
      vectors++;
      if (tap_state !== TAP_TLR || tdo_oe !== 1'b0 || tdo !== 1'b0) begin
         miscompares++;
         $display("FAIL five_tms_ones: state=%h oe=%b tdo=%b want %h 0 0", tap_state, tdo_oe, tdo, TAP_TLR);
      end
   endtask

   task automatic test_idcode();
      logic [31:0] idc = 32'h10000001;
      logic [1:0]  ob;
      logic        e;
      walk(8'b0010, 4);
      for (int i = 0; i < 16; i++) exp_q.push_back(idc[i]);
      shift_bits(16, 32'h0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL idcode_lo bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b0, 1);
      #(TCK_HALF);
      vectors++;
      if (tap_state !== TAP_PAUSE_DR || tdo_oe !== 1'b0) begin
         miscompares++; $display("FAIL pause_dr: state=%h oe=%b want %h 0", tap_state, tdo_oe, TAP_PAUSE_DR);
      end
      walk(8'b01, 2);
      for (int i = 16; i < 32; i++) exp_q.push_back(idc[i]);
      shift_bits(16, 32'h0, 1'b1);
      for (int i = 16; i < 32; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL idcode_hi bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
      #(TCK_HALF);
      vectors++;
      if (tap_state !== TAP_RTI) begin
         miscompares++; $display("FAIL idcode_to_rti: state=%h want %h", tap_state, TAP_RTI);
      end
   endtask

   task automatic test_ir_bypass();
      logic [4:0]  ir_exp = 5'b00001;
      logic [31:0] din = 32'hA5;
      logic [1:0]  ob;
      logic        e;
      walk(8'b0011, 4);
      for (int i = 0; i < 5; i++) exp_q.push_back(ir_exp[i]);
      shift_bits(5, 32'(OPC_BYPASS), 1'b1);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL ir_capture bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
      walk(8'b001, 3);
      exp_q.push_back(1'b0);
      for (int i = 1; i < 8; i++) exp_q.push_back(din[i-1]);
      shift_bits(8, din, 1'b1);
      for (int i = 0; i < 8; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL bypass bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
   endtask

   task automatic test_tlr_reload();
      logic [31:0] idc = 32'h10000001;
      logic [1:0]  ob;
      logic        e;
      walk(8'b11111, 5);
      #(TCK_HALF);
      vectors++;
      if (tap_state !== TAP_TLR) begin
         miscompares++; $display("FAIL tlr_walk: state=%h want %h", tap_state, TAP_TLR);
      end
      walk(8'b0010, 4);
      for (int i = 0; i < 32; i++) exp_q.push_back(idc[i]);
      shift_bits(32, 32'h0, 1'b1);
      for (int i = 0; i < 32; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL tlr_reload bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
   endtask

   task automatic test_user();
      logic [31:0] din = 32'h12345678;
      logic [31:0] cap = 32'hDEADBEEF;
      logic [31:0] exp_tdo, exp_upd;
      int          exp_vld, vld0;
      logic [1:0]  ob;
      logic        e;
`ifdef JTAG_TAP_USER_DR_EN
      exp_tdo = cap; exp_upd = din; exp_vld = 1;
`else
      exp_tdo = {din[30:0], 1'b0}; exp_upd = 32'h0; exp_vld = 0;
`endif
      user_capture = cap;
      load_ir(5'h10);
      vld0 = vld_cnt;
      walk(8'b001, 3);
      for (int i = 0; i < 32; i++) exp_q.push_back(exp_tdo[i]);
      shift_bits(32, din, 1'b1);
      for (int i = 0; i < 32; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL user_shift bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
      #(TCK_HALF);
      vectors++;
      if (user_update !== exp_upd) begin
         miscompares++; $display("FAIL user_update: got %h want %h", user_update, exp_upd);
      end
      vectors++;
      if (vld_cnt - vld0 !== exp_vld) begin
         miscompares++; $display("FAIL user_vld_pulse: got %0d cycles want %0d", vld_cnt - vld0, exp_vld);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [31:0] idc = 32'h10000001;
      logic [31:0] exp_upd;
      int          vld0;
      logic [1:0]  ob;
      logic        e;
`ifdef JTAG_TAP_USER_DR_EN
      exp_upd = 32'h12345678;
`else
      exp_upd = 32'h0;
`endif
      walk(8'b001, 3);
      shift_bits(10, 32'h3FF, 1'b0);
      obs_q.delete();
      vld0 = vld_cnt;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (tap_state !== TAP_TLR || tdo_oe !== 1'b0) begin
         miscompares++; $display("FAIL midshift_reset: state=%h oe=%b want %h 0", tap_state, tdo_oe, TAP_TLR);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (vld_cnt - vld0 !== 0 || user_update !== exp_upd) begin
         miscompares++;
         $display("FAIL midshift_no_update: vld=%0d upd=%h want 0 %h", vld_cnt - vld0, user_update, exp_upd);
      end
      walk(8'b0010, 4);
      for (int i = 0; i < 32; i++) exp_q.push_back(idc[i]);
      shift_bits(32, 32'h0, 1'b1);
      for (int i = 0; i < 32; i++) begin
         e = exp_q.pop_front(); ob = obs_q.pop_front();
         vectors++;
         if (ob !== {1'b1, e}) begin
            miscompares++; $display("FAIL post_reset_idcode bit %0d: oe/tdo=%b want %b", i, ob, {1'b1, e});
         end
      end
      walk(8'b01, 2);
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_ir_bypass();
      test_tlr_reload();
      test_user();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
